// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between NrHosts requesters.
// An in-order ID FIFO records which host issued each accepted transaction so its response goes back to that host.
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrHosts-1:0]             host_req_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*4-1:0]           host_be_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [DataWidth-1:0]           host_rdata_o,
  output logic                           host_err_o,
  output logic                           dev_req_o,
  input  logic                           dev_gnt_i,
  output logic [AddrWidth-1:0]           dev_addr_o,
  output logic                           dev_we_o,
  output logic [3:0]                     dev_be_o,
  output logic [DataWidth-1:0]           dev_wdata_o,
  input  logic                           dev_rvalid_i,
  input  logic [DataWidth-1:0]           dev_rdata_i,
  input  logic                           dev_err_i,
  output logic                           busy_o
);

  localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] sel, sel_lo, sel_hi;
  logic            found_hi;
  logic            any_req;
  logic            full;
  logic            accept;
  logic            resp;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    found_hi = 1'b0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        sel_lo = IdxW'(h);
        if (IdxW'(h) >= rr_ptr_q) begin
          sel_hi   = IdxW'(h);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  assign any_req   = |host_req_i;
  assign full      = (cnt_q == CntW'(MaxOutstanding));
  assign dev_req_o = any_req & ~full & ~rst_i;
  assign accept    = dev_req_o & dev_gnt_i;
  assign resp      = dev_rvalid_i & (cnt_q != '0) & ~rst_i;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    if (accept) host_gnt_o[sel] = 1'b1;
    if (resp) host_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    if (any_req && !rst_i) begin
      dev_addr_o  = host_addr_i[sel*AddrWidth +: AddrWidth];
      dev_we_o    = host_we_i[sel];
      dev_be_o    = host_be_i[sel*4 +: 4];
      dev_wdata_o = host_wdata_i[sel*DataWidth +: DataWidth];
    end
  end

  assign host_rdata_o = rst_i ? '0 : dev_rdata_i;
  assign host_err_o   = dev_err_i & ~rst_i;
  assign busy_o       = (cnt_q != '0) & ~rst_i;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      rr_ptr_d = (sel == IdxW'(NrHosts - 1)) ? '0 : sel + 1'b1;
      wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (resp) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({accept, resp})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (accept) fifo_q[wr_ptr_q] <= sel;
    end
  end

  // A response with nothing outstanding is dropped; flag it, and treat one racing its own accept as a device bug.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(dev_rvalid_i && cnt_q == '0))
        else $warning("bus_host_arbiter: spurious response dropped");
      assert (!(dev_rvalid_i && cnt_q == '0 && accept))
        else $error("bus_host_arbiter: response in the same cycle as its accept");
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model of round-robin grant and in-order responses.
module tb_bus_host_arbiter;
  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NH-1:0]     host_req_i;
  logic [NH-1:0]     host_gnt_o;
  logic [NH*AW-1:0]  host_addr_i;
  logic [NH-1:0]     host_we_i;
  logic [NH*4-1:0]   host_be_i;
  logic [NH*DW-1:0]  host_wdata_i;
  logic [NH-1:0]     host_rvalid_o;
  logic [DW-1:0]     host_rdata_o;
  logic              host_err_o;
  logic              dev_req_o;
  logic              dev_gnt_i;
  logic [AW-1:0]     dev_addr_o;
  logic              dev_we_o;
  logic [3:0]        dev_be_o;
  logic [DW-1:0]     dev_wdata_o;
  logic              dev_rvalid_i;
  logic [DW-1:0]     dev_rdata_i;
  logic              dev_err_i;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  int rr = 0;
  int q[$];

  bus_host_arbiter #(.NrHosts(NH), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int msel(input logic [NH-1:0] r);
    for (int k = 0; k < NH; k++) begin
      if (r[(rr + k) % NH]) return (rr + k) % NH;
    end
    return 0;
  endfunction

  // Compare every output at the falling edge, then advance the model across the coming rising edge.
  task automatic cycle(input string tag);
    int s;
    bit live, anyr, dreq, acc, rsp;
    logic [NH-1:0] eg, ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [3:0]    eb;
    @(negedge clk_i);
    live = !rst_i;
    s    = msel(host_req_i);
    anyr = live && (|host_req_i);
    dreq = anyr && (q.size() < MO);
    acc  = dreq && dev_gnt_i;
    rsp  = live && dev_rvalid_i && (q.size() > 0);
    eg = '0;
    if (acc) eg[s] = 1'b1;
    ev = '0;
    if (rsp) ev[q[0]] = 1'b1;
    ea = anyr ? host_addr_i[s*AW +: AW] : '0;
    ed = anyr ? host_wdata_i[s*DW +: DW] : '0;
    eb = anyr ? host_be_i[s*4 +: 4] : '0;
    chk({tag, "_dev_req"}, dev_req_o, dreq);
    chk({tag, "_gnt"}, host_gnt_o, eg);
    chk({tag, "_rvalid"}, host_rvalid_o, ev);
    chk({tag, "_addr"}, dev_addr_o, ea);
    chk({tag, "_we"}, dev_we_o, anyr && host_we_i[s]);
    chk({tag, "_be"}, dev_be_o, eb);
    chk({tag, "_wdata"}, dev_wdata_o, ed);
    chk({tag, "_rdata"}, host_rdata_o, live ? dev_rdata_i : '0);
    chk({tag, "_err"}, host_err_o, live && dev_err_i);
    chk({tag, "_busy"}, busy_o, live && (q.size() != 0));
    if (!live) begin
      q.delete();
      rr = 0;
    end else begin
      if (rsp) void'(q.pop_front());
      if (acc) begin
        q.push_back(s);
        rr = (s + 1) % NH;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step(input string tag);
    cycle(tag);
    tick();
  endtask

  initial begin
    logic [1:0] cont_g [3];
    logic [1:0] cont_v [3];
    cont_g = '{2'b10, 2'b01, 2'b10};
    cont_v = '{2'b01, 2'b10, 2'b01};

    rst_i = 1'b1; host_req_i = 2'b11; host_addr_i = '0; host_we_i = '0;
    host_be_i = '0; host_wdata_i = '0; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b0;
    dev_rdata_i = '0; dev_err_i = 1'b0;
    cycle("reset");
    chk("reset_req_gated", dev_req_o, 0);
    tick();
    rst_i = 1'b0; host_req_i = '0;
    step("idle");

    // single host read
    host_req_i = 2'b10; host_addr_i[AW +: AW] = 32'h0010_0010; host_be_i = 8'hF0;
    cycle("single_a");
    chk("single_gnt", host_gnt_o, 2'b10);
    chk("single_addr", dev_addr_o, 32'h0010_0010);
    chk("single_busy_pre", busy_o, 0);
    tick();
    host_req_i = '0; dev_rvalid_i = 1'b1; dev_rdata_i = 32'hDEAD_BEEF;
    cycle("single_r");
    chk("single_rvalid", host_rvalid_o, 2'b10);
    chk("single_rdata", host_rdata_o, 32'hDEAD_BEEF);
    chk("single_busy", busy_o, 1);
    tick();
    dev_rvalid_i = 1'b0;
    cycle("single_done");
    chk("single_busy_post", busy_o, 0);
    tick();

    // contention, responses one cycle behind
    host_req_i = 2'b11; host_addr_i = {32'h0000_1111, 32'h0000_2222};
    host_wdata_i = {32'hAAAA_0001, 32'hBBBB_0000}; host_we_i = 2'b01;
    cycle("cont0");
    chk("cont_gnt0", host_gnt_o, 2'b01);
    tick();
    for (int i = 0; i < 3; i++) begin
      dev_rvalid_i = 1'b1; dev_rdata_i = 32'h100 + i;
      cycle("cont");
      chk("cont_gnt", host_gnt_o, cont_g[i]);
      chk("cont_rvalid", host_rvalid_o, cont_v[i]);
      tick();
    end
    host_req_i = '0;
    cycle("cont_drain");
    chk("cont_rvalid_last", host_rvalid_o, 2'b10);
    tick();
    dev_rvalid_i = 1'b0;
    step("cont_idle");

    // back-pressure at MaxOutstanding
    host_req_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cycle("bp");
      chk("bp_dev_req", dev_req_o, (i < 2) ? 1 : 0);
      tick();
    end
    dev_rvalid_i = 1'b1; dev_err_i = 1'b1;
    cycle("bp_pop");
    chk("bp_req_full_pop", dev_req_o, 0);
    chk("bp_rvalid", host_rvalid_o, 2'b01);
    chk("bp_err", host_err_o, 1);
    tick();
    dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
    cycle("bp_reopen");
    chk("bp_req_reopen", dev_req_o, 1);
    tick();
    host_req_i = '0; dev_rvalid_i = 1'b1;
    step("bp_drain0");
    step("bp_drain1");
    dev_rvalid_i = 1'b0;

    // device stall
    host_req_i = 2'b01; host_addr_i[0 +: AW] = 32'hA000_0040; dev_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall_gnt", host_gnt_o, 2'b00);
      chk("stall_addr", dev_addr_o, 32'hA000_0040);
      tick();
    end
    host_req_i = 2'b11; dev_gnt_i = 1'b1;
    cycle("stall_release");
    chk("stall_gnt_rr", host_gnt_o, 2'b10);
    tick();

    // simultaneous push and pop with one outstanding
    host_req_i = 2'b01; dev_rvalid_i = 1'b1;
    cycle("pp");
    chk("pp_gnt", host_gnt_o, 2'b01);
    chk("pp_rvalid_old", host_rvalid_o, 2'b10);
    tick();
    host_req_i = '0;
    cycle("pp_next");
    chk("pp_busy_kept", busy_o, 1);
    chk("pp_rvalid_new", host_rvalid_o, 2'b01);
    tick();
    dev_rvalid_i = 1'b0;
    step("pp_idle");

    // reset mid-flight
    host_req_i = 2'b11;
    step("rm_a");
    step("rm_b");
    rst_i = 1'b1; dev_rvalid_i = 1'b1;
    cycle("rm_reset");
    tick();
    rst_i = 1'b0; host_req_i = '0;
    cycle("rm_stray");
    chk("rm_stray_rvalid", host_rvalid_o, 2'b00);
    chk("rm_busy", busy_o, 0);
    tick();
    dev_rvalid_i = 1'b0; host_req_i = 2'b11;
    cycle("rm_grant");
    chk("rm_gnt_host0", host_gnt_o, 2'b01);
    tick();
    host_req_i = '0; dev_rvalid_i = 1'b1;
    step("rm_drain");
    dev_rvalid_i = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      host_req_i   = NH'($urandom);
      host_addr_i  = {$urandom, $urandom};
      host_wdata_i = {$urandom, $urandom};
      host_be_i    = 8'($urandom);
      host_we_i    = NH'($urandom);
      dev_gnt_i    = ($urandom_range(0, 3) != 0);
      dev_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      dev_rdata_i  = $urandom;
      dev_err_i    = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    host_req_i = '0;
    for (int i = 0; i < MO + 1; i++) begin
      dev_rvalid_i = (q.size() > 0);
      step("rand_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
